// File: rtl/key_stim_pkg.sv
// Shared constants for the key stimulus generator: step count, idle key level,
// the 4x8 key pattern ROM and the sequencer state encoding.
package key_stim_pkg;

  localparam int SEQ_STEPS = 8;
  localparam logic [3:0] KEY_IDLE = 4'h0;
  localparam logic [3:0] KEY_ALL  = 4'hF;

  typedef enum logic {IDLE, DRIVE} state_t;

  // Row = pattern select, column = step index.
  localparam logic [3:0] PATTERN_ROM [4][SEQ_STEPS] = '{
    '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0},
    '{4'hF, 4'h7, 4'h3, 4'h1, 4'h0, 4'h8, 4'hC, 4'hE},
    '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h8, 4'h4, 4'h0},
    '{4'hF, 4'hE, 4'hD, 4'hB, 4'h7, 4'h0, 4'h1, 4'hF}
  };

  function automatic logic [3:0] pattern_at(input logic [1:0] sel, input logic [2:0] idx);
    return PATTERN_ROM[sel][idx];
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Step hold timer: down-counter loaded with HOLD_CYCLES-1; expire is high on the
// last cycle of a hold (count 0). The owner ignores expire while idle.
module hold_timer #(
  parameter int HOLD_CYCLES = 50000
) (
  input  logic clk50M,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/key_stim_gen.sv
// Drives key_out through one of four fixed 8-step patterns, each step held for
// HOLD_CYCLES clocks, with a registered reference model of the key gate.
module key_stim_gen
  import key_stim_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] seq_sel,
  output logic [3:0] key_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] step,
  output logic       gate_model
);

  // Control handshake: start is a level request, accepted only on an edge where
  // the sequencer is idle and abort is low (seq_sel is latched on that edge).
  // abort is honoured on any edge while driving and always beats start.
  // done pulses for one cycle only on normal completion, never on abort.

  state_t     state, state_nxt;
  logic [1:0] sel_q, sel_nxt;
  logic [3:0] key_nxt;
  logic [2:0] step_nxt;
  logic       busy_nxt, done_nxt, gate_nxt;
  logic       load, expire;

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk50M (clk50M),
    .rst_n  (rst_n),
    .load   (load),
    .expire (expire)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    key_nxt   = key_out;
    step_nxt  = step;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = DRIVE;
          sel_nxt   = seq_sel;
          step_nxt  = 3'd0;
          key_nxt   = pattern_at(seq_sel, 3'd0);
          busy_nxt  = 1'b1;
          load      = 1'b1;
        end
      end
      DRIVE: begin
        if (abort || (expire && step == 3'(SEQ_STEPS - 1))) begin
          state_nxt = IDLE;
          key_nxt   = KEY_IDLE;
          step_nxt  = 3'd0;
          busy_nxt  = 1'b0;
          done_nxt  = !abort;
        end else if (expire) begin
          step_nxt  = step + 3'd1;
          key_nxt   = pattern_at(sel_q, step + 3'd1);
          load      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gate model looks at the key value being registered, so it stays aligned with key_out.
  always_comb begin
    gate_nxt = gate_model;
    if (key_nxt == KEY_ALL) begin
      gate_nxt = 1'b1;
    end else if (key_nxt == KEY_IDLE) begin
      gate_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_q      <= 2'd0;
      key_out    <= KEY_IDLE;
      step       <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gate_model <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel_q      <= sel_nxt;
      key_out    <= key_nxt;
      step       <= step_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      gate_model <= gate_nxt;
    end
  end

endmodule

// File: doc/key_stim_gen.md
# key_stim_gen

Stimulus generator for the four key lines sampled by the key-combination gate trigger. On a start request it drives `key_out[3:0]` through one of four fixed 8-step patterns, holding each pattern for a programmable number of clocks. A registered reference model of the gate (`gate_model`) runs alongside, so on-board or bench comparison against the trigger's LED output needs no extra logic. It sits between the board's control logic or test harness and the key inputs of the gate trigger.

## Interface
- `HOLD_CYCLES`, default 50000 (1 ms at 50 MHz): clocks each step is held; legal range ≥ 1.
- `clk50M`, input, 1: system clock; all logic on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: level-sampled request; accepted only in IDLE.
- `abort`, input, 1: synchronous cancel; takes priority over `start`.
- `seq_sel`, input, 2: pattern select; latched when `start` is accepted.
- `key_out`, output, 4: driven key levels; bit i goes to key i.
- `busy`, output, 1: high while a sequence is being driven.
- `done`, output, 1: one-cycle pulse when a sequence completes normally.
- `step`, output, 3: index of the step currently driven; 0 when idle.
- `gate_model`, output, 1: expected trigger state for the current `key_out`.

## Operation
- Clock and reset: one clock, `clk50M`; reset `rst_n` is asynchronous, active-low.
- Reset values: `key_out`=4'h0, `busy`=0, `done`=0, `step`=0, `gate_model`=0, state IDLE.
- Pattern ROM, steps 0..7 in hex:
  - sel 0: F,0,F,0,F,0,F,0
  - sel 1: F,7,3,1,0,8,C,E
  - sel 2: 1,2,4,8,F,8,4,0
  - sel 3: F,E,D,B,7,0,1,F
- States:
  - IDLE: `key_out`=0, `busy`=0. `start`=1 and `abort`=0 → DRIVE. Latch `seq_sel`, `step`=0, load the hold timer.
  - DRIVE: `key_out`=ROM[sel][step], `busy`=1.
    - When the timer expires and `step`<7: `step`+1, reload the timer.
    - When the timer expires and `step`=7: go to IDLE, `key_out`=0, `step`=0, `done`=1 for one cycle.
  - `abort`=1 in DRIVE: go to IDLE next edge. `key_out`=0, `step`=0, `busy`=0, no `done` pulse.
- `start` while busy is ignored; a second sequence needs `start` high while in IDLE.
- If `start` stays high, a new sequence begins the cycle after `done`, i.e. back-to-back with one idle cycle.
- `gate_model` is registered together with `key_out` and evaluated on the next value of `key_out`:
  - next `key_out`=F → 1
  - next `key_out`=0 → 0
  - otherwise hold the current value.
  - Return to idle (0) therefore clears it.
- Reset mid-sequence: all outputs go to reset values immediately; the sequence is not resumed.

## Timing
- `start` sampled high at edge N → from edge N+1: `key_out`=step 0, `busy`=1.
- Step k is visible for exactly `HOLD_CYCLES` clocks: edges N+1+k·H through N+(k+1)·H.
- At edge N+8·H+1: `key_out`=0, `busy`=0, `done`=1. `done`=0 at the next edge.
- Total busy time is exactly 8·H clocks.
- Hold timer is a down-counter of width $clog2(HOLD_CYCLES+1).
  - Loaded with H−1; expires at count 0.
  - H=1 yields one clock per step.

## Structure
- Package `key_stim_pkg` holds:
  - `SEQ_STEPS`=8
  - `KEY_IDLE`=4'h0
  - the 4×8×4-bit pattern ROM constant
  - the state enum {IDLE, DRIVE}
- Sub-module `hold_timer`:
  - Parameter `HOLD_CYCLES`.
  - Inputs: `load`.
  - Output: `expire`, a one-cycle pulse on the last cycle of the hold.
  - Instantiated once.

## Test plan
All scenarios use HOLD_CYCLES=4.

1. Reset asserted mid-run → all outputs 0 on the same cycle. After release, `key_out`=0 until the next `start`.
2. `start` pulse with sel=0 → `key_out` sequence F,0,F,0,F,0,F,0, each for 4 clocks. `gate_model` follows 1,0,1,0,… `done` pulses at start+33; `busy` is high for exactly 32 clocks.
3. sel=1 → `gate_model` 1,1,1,1,0,0,0,0. sel=3 → `gate_model` 1,1,1,1,1,0,0,1, then 0 when idle.
4. `abort` asserted at step 3 of sel=2 (`key_out`=8) → next cycle `key_out`=0, `busy`=0, `step`=0; no `done` pulse.
5. `start` held high continuously, sel=2 → two sequences separated by exactly one idle cycle with `key_out`=0. `done` pulses at the end of each sequence.
6. `start` pulses while busy, and `seq_sel` changed mid-run → the running sequence is unaffected and completes with the originally latched pattern.
